// File: rtl/ucc_monitor_pkg.sv
// Shared types for the untrusted-code-region monitor: region FSM state
// encoding, violation cause codes and the inclusive region hit test.
package ucc_monitor_pkg;

    typedef enum logic [1:0] {
        ST_OUT  = 2'd0,
        ST_IN   = 2'd1,
        ST_KILL = 2'd2
    } ucc_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_ENTRY = 3'd1,
        CAUSE_EXIT  = 3'd2,
        CAUSE_IRQ   = 3'd3,
        CAUSE_WRITE = 3'd4,
        CAUSE_DMA   = 3'd5
    } ucc_cause_e;

    // An inverted region (lo > hi) can never satisfy both bounds, so it never hits.
    function automatic logic region_hit(input logic [15:0] a,
                                        input logic [15:0] lo,
                                        input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/ucc_monitor_if.sv
// Bus bundle between the CPU/DMA/CR side and the monitor: observed
// execution and memory traffic, region bounds, and the violation report.
interface ucc_monitor_if #(
    parameter int NUM_UCC = 3
);
    logic [15:0]        pc;
    logic               irq;
    logic               data_wr;
    logic [15:0]        data_addr;
    logic               dma_en;
    logic [15:0]        dma_addr;
    logic [15:0]        ucc_min [NUM_UCC];
    logic [15:0]        ucc_max [NUM_UCC];
    logic               exec_reset;
    logic [NUM_UCC-1:0] in_ucc;
    logic [2:0]         viol_id;
    logic [2:0]         viol_cause;

    modport master (
        output pc, irq, data_wr, data_addr, dma_en, dma_addr, ucc_min, ucc_max,
        input  exec_reset, in_ucc, viol_id, viol_cause
    );

    modport slave (
        input  pc, irq, data_wr, data_addr, dma_en, dma_addr, ucc_min, ucc_max,
        output exec_reset, in_ucc, viol_id, viol_cause
    );
endinterface

// File: rtl/ucc_monitor_region_fsm.sv
// One region's OUT/IN/KILL tracker. Reports this cycle's violation (if any)
// with the lowest applicable cause code; KILL is held until reset.
module ucc_region_fsm
    import ucc_monitor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_i,
    input  logic [15:0] prev_pc_i,
    input  logic        irq_i,
    input  logic        data_wr_i,
    input  logic [15:0] data_addr_i,
    input  logic        dma_en_i,
    input  logic [15:0] dma_addr_i,
    input  logic [15:0] ucc_min_i,
    input  logic [15:0] ucc_max_i,
    output logic        in_ucc_o,
    output logic        viol_o,
    output ucc_cause_e  cause_o
);

    ucc_state_e state_q, state_d;
    logic       pc_hit, wr_hit, dma_hit;

    assign pc_hit  = region_hit(pc_i, ucc_min_i, ucc_max_i);
    assign wr_hit  = data_wr_i && region_hit(data_addr_i, ucc_min_i, ucc_max_i);
    assign dma_hit = dma_en_i  && region_hit(dma_addr_i,  ucc_min_i, ucc_max_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OUT;
        end else begin
            state_q <= state_d;
        end
    end

    // Checks are ordered by cause code so the first match is the one reported.
    always_comb begin
        state_d = state_q;
        cause_o = CAUSE_NONE;
        case (state_q)
            ST_OUT: begin
                if (pc_hit && (pc_i != ucc_min_i)) cause_o = CAUSE_ENTRY;
                else if (wr_hit)                   cause_o = CAUSE_WRITE;
                else if (dma_hit)                  cause_o = CAUSE_DMA;
                else if (pc_hit)                   state_d = ST_IN;
            end
            ST_IN: begin
                if (!pc_hit && (prev_pc_i != ucc_max_i)) cause_o = CAUSE_EXIT;
                else if (irq_i)                          cause_o = CAUSE_IRQ;
                else if (wr_hit)                         cause_o = CAUSE_WRITE;
                else if (dma_hit)                        cause_o = CAUSE_DMA;
                else if (!pc_hit)                        state_d = ST_OUT;
            end
            default: ;
        endcase
        if (cause_o != CAUSE_NONE) state_d = ST_KILL;
    end

    assign viol_o   = (cause_o != CAUSE_NONE);
    assign in_ucc_o = (state_q == ST_IN);

endmodule

// File: rtl/ucc_monitor.sv
// Untrusted code monitor: one FSM per region, shared prev_pc register and a
// sticky, lowest-index-first violation report driving exec_reset.
module ucc_monitor
    import ucc_monitor_pkg::*;
#(
    parameter int NUM_UCC = 3
) (
    input  logic          clk,
    input  logic          puc_rst,
    ucc_monitor_if.slave  bus
);

    logic [15:0]        prev_pc_q;
    logic [NUM_UCC-1:0] in_ucc;
    logic [NUM_UCC-1:0] viol;
    ucc_cause_e         cause [NUM_UCC];

    logic               exec_reset_q, exec_reset_d;
    logic [2:0]         viol_id_q, viol_id_d;
    ucc_cause_e         viol_cause_q, viol_cause_d;
    logic [2:0]         first_id;
    ucc_cause_e         first_cause;
    logic               latch_en;

    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            prev_pc_q <= 16'h0000;
        end else begin
            prev_pc_q <= bus.pc;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_UCC; gi++) begin : g_region
            ucc_region_fsm u_fsm (
                .clk         (clk),
                .rst         (puc_rst),
                .pc_i        (bus.pc),
                .prev_pc_i   (prev_pc_q),
                .irq_i       (bus.irq),
                .data_wr_i   (bus.data_wr),
                .data_addr_i (bus.data_addr),
                .dma_en_i    (bus.dma_en),
                .dma_addr_i  (bus.dma_addr),
                .ucc_min_i   (bus.ucc_min[gi]),
                .ucc_max_i   (bus.ucc_max[gi]),
                .in_ucc_o    (in_ucc[gi]),
                .viol_o      (viol[gi]),
                .cause_o     (cause[gi])
            );
        end
    endgenerate

    // Scan downward so the lowest violating index is the last one written.
    always_comb begin
        first_id    = '0;
        first_cause = CAUSE_NONE;
        for (int i = NUM_UCC - 1; i >= 0; i--) begin
            if (viol[i]) begin
                first_id    = 3'(i);
                first_cause = cause[i];
            end
        end
    end

    assign latch_en     = !exec_reset_q && (|viol);
    assign exec_reset_d = exec_reset_q || (|viol);
    assign viol_id_d    = latch_en ? first_id    : viol_id_q;
    assign viol_cause_d = latch_en ? first_cause : viol_cause_q;

    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            exec_reset_q <= 1'b0;
            viol_id_q    <= 3'd0;
            viol_cause_q <= CAUSE_NONE;
        end else begin
            exec_reset_q <= exec_reset_d;
            viol_id_q    <= viol_id_d;
            viol_cause_q <= viol_cause_d;
        end
    end

    assign bus.exec_reset = exec_reset_q;
    assign bus.in_ucc     = in_ucc;
    assign bus.viol_id    = viol_id_q;
    assign bus.viol_cause = viol_cause_q;

endmodule

// File: tb/tb_ucc_monitor.sv
// Self-checking bench for ucc_monitor: directed scenarios plus randomized
// traffic compared against a region-rule reference model.
module tb_ucc_monitor;

    localparam int NUM = 3;

    logic clk = 1'b0;
    logic puc_rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    ucc_monitor_if #(.NUM_UCC(NUM)) bus ();

    ucc_monitor #(.NUM_UCC(NUM)) dut (
        .clk     (clk),
        .puc_rst (puc_rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: whether each region is being executed / has been killed.
    bit          m_in   [NUM];
    bit          m_kill [NUM];
    logic [15:0] m_prev;
    logic        m_exec;
    logic [2:0]  m_id;
    logic [2:0]  m_cause;

    function automatic bit hit(input logic [15:0] a, input logic [15:0] lo, input logic [15:0] hi);
        return (lo <= a) && (a <= hi);
    endfunction

    function automatic logic [NUM-1:0] m_in_vec();
        logic [NUM-1:0] v;
        for (int i = 0; i < NUM; i++) v[i] = m_in[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) begin
            m_in[i]   = 0;
            m_kill[i] = 0;
        end
        m_prev = 16'h0; m_exec = 0; m_id = 0; m_cause = 0;
    endtask

    task automatic model_step();
        bit latched;
        int c;
        bit ph;
        latched = m_exec;
        for (int i = 0; i < NUM; i++) begin
            if (m_kill[i]) continue;
            ph = hit(bus.pc, bus.ucc_min[i], bus.ucc_max[i]);
            c = 0;
            if (!m_in[i] && ph && bus.pc != bus.ucc_min[i])                     c = 1;
            else if (m_in[i] && !ph && m_prev != bus.ucc_max[i])                c = 2;
            else if (m_in[i] && bus.irq)                                        c = 3;
            else if (bus.data_wr && hit(bus.data_addr, bus.ucc_min[i], bus.ucc_max[i])) c = 4;
            else if (bus.dma_en && hit(bus.dma_addr, bus.ucc_min[i], bus.ucc_max[i]))   c = 5;
            if (c != 0) begin
                m_kill[i] = 1;
                m_in[i]   = 0;
                if (!latched) begin
                    latched = 1;
                    m_id    = 3'(i);
                    m_cause = 3'(c);
                end
            end else begin
                m_in[i] = ph;
            end
        end
        m_exec = latched;
        m_prev = bus.pc;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        bus.irq = 0; bus.data_wr = 0; bus.dma_en = 0;
    endtask

    task automatic do_reset();
        puc_rst = 1;
        #2;
        puc_rst = 0;
        model_reset();
    endtask

    task automatic set_default_regions();
        bus.ucc_min[0] = 16'hE000; bus.ucc_max[0] = 16'hE0FE;
        bus.ucc_min[1] = 16'hF000; bus.ucc_max[1] = 16'hEF00;
        bus.ucc_min[2] = 16'hE040; bus.ucc_max[2] = 16'hE060;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (bus.exec_reset !== 1'b0) begin n_fail++; $display("FAIL reset_exec_reset: got %b want 0", bus.exec_reset); end
        n_checks++; if (bus.in_ucc !== 3'b000) begin n_fail++; $display("FAIL reset_in_ucc: got %b want 000", bus.in_ucc); end
        n_checks++; if (bus.viol_id !== 3'd0) begin n_fail++; $display("FAIL reset_viol_id: got %0d want 0", bus.viol_id); end
        n_checks++; if (bus.viol_cause !== 3'd0) begin n_fail++; $display("FAIL reset_viol_cause: got %0d want 0", bus.viol_cause); end
        @(posedge clk); #1;
        puc_rst = 0;
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_legal_pass();
        logic [15:0] pcs [5];
        logic [2:0]  exp_in [5];
        pcs = '{16'hC000, 16'hE000, 16'hE002, 16'hE0FE, 16'hC010};
        exp_in = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b000};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            bus.pc = pcs[k];
            tick();
            n_checks++; if (bus.in_ucc !== exp_in[k]) begin n_fail++; $display("FAIL legal_in_ucc[%0d]: got %b want %b", k, bus.in_ucc, exp_in[k]); end
            n_checks++; if (bus.exec_reset !== 1'b0) begin n_fail++; $display("FAIL legal_exec_reset[%0d]: got %b want 0", k, bus.exec_reset); end
            $display("legal pass pc=%h in_ucc=%b exec_reset=%b", pcs[k], bus.in_ucc, bus.exec_reset);
        end
    endtask

    task automatic test_min_eq_max();
        logic [15:0] pcs [3];
        logic [2:0]  exp_in [3];
        pcs = '{16'hC000, 16'hD000, 16'hC100};
        exp_in = '{3'b000, 3'b100, 3'b000};
        bus.ucc_min[2] = 16'hD000; bus.ucc_max[2] = 16'hD000;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.pc = pcs[k];
            tick();
            n_checks++; if (bus.in_ucc !== exp_in[k]) begin n_fail++; $display("FAIL single_in_ucc[%0d]: got %b want %b", k, bus.in_ucc, exp_in[k]); end
            n_checks++; if (bus.exec_reset !== 1'b0) begin n_fail++; $display("FAIL single_exec_reset[%0d]: got %b want 0", k, bus.exec_reset); end
            $display("single-address pc=%h in_ucc=%b exec_reset=%b", pcs[k], bus.in_ucc, bus.exec_reset);
        end
        set_default_regions();
    endtask

    task automatic test_illegal_entry();
        do_reset();
        bus.pc = 16'hC000; tick();
        n_checks++; if (bus.exec_reset !== 1'b0) begin n_fail++; $display("FAIL entry_pre_exec_reset: got %b want 0", bus.exec_reset); end
        bus.pc = 16'hE010; tick();
        n_checks++; if (bus.exec_reset !== 1'b1) begin n_fail++; $display("FAIL entry_exec_reset: got %b want 1", bus.exec_reset); end
        n_checks++; if (bus.viol_id !== 3'd0) begin n_fail++; $display("FAIL entry_viol_id: got %0d want 0", bus.viol_id); end
        n_checks++; if (bus.viol_cause !== 3'd1) begin n_fail++; $display("FAIL entry_viol_cause: got %0d want 1", bus.viol_cause); end
        $display("illegal entry exec_reset=%b id=%0d cause=%0d", bus.exec_reset, bus.viol_id, bus.viol_cause);
    endtask

    task automatic test_irq();
        do_reset();
        bus.pc = 16'hC000; tick();
        bus.pc = 16'hE000; tick();
        bus.pc = 16'hE002; tick();
        bus.pc = 16'hE004; bus.irq = 1; tick();
        n_checks++; if (bus.exec_reset !== 1'b1) begin n_fail++; $display("FAIL irq_exec_reset: got %b want 1", bus.exec_reset); end
        n_checks++; if (bus.viol_cause !== 3'd3) begin n_fail++; $display("FAIL irq_viol_cause: got %0d want 3", bus.viol_cause); end
        n_checks++; if (bus.in_ucc !== 3'b000) begin n_fail++; $display("FAIL irq_in_ucc: got %b want 000", bus.in_ucc); end
        bus.pc = 16'hC000; bus.data_wr = 1; bus.data_addr = 16'hE050; tick();
        bus.dma_en = 1; bus.dma_addr = 16'hE045; tick();
        n_checks++; if (bus.viol_id !== 3'd0) begin n_fail++; $display("FAIL irq_sticky_id: got %0d want 0", bus.viol_id); end
        n_checks++; if (bus.viol_cause !== 3'd3) begin n_fail++; $display("FAIL irq_sticky_cause: got %0d want 3", bus.viol_cause); end
        n_checks++; if (bus.exec_reset !== 1'b1) begin n_fail++; $display("FAIL irq_sticky_exec: got %b want 1", bus.exec_reset); end
        $display("irq violation id=%0d cause=%0d exec_reset=%b", bus.viol_id, bus.viol_cause, bus.exec_reset);
    endtask

    task automatic test_write_overlap();
        do_reset();
        bus.pc = 16'hC000; tick();
        bus.data_wr = 1; bus.data_addr = 16'hE050; tick();
        n_checks++; if (bus.exec_reset !== 1'b1) begin n_fail++; $display("FAIL overlap_exec_reset: got %b want 1", bus.exec_reset); end
        n_checks++; if (bus.viol_id !== 3'd0) begin n_fail++; $display("FAIL overlap_viol_id: got %0d want 0", bus.viol_id); end
        n_checks++; if (bus.viol_cause !== 3'd4) begin n_fail++; $display("FAIL overlap_viol_cause: got %0d want 4", bus.viol_cause); end
        $display("overlap write id=%0d cause=%0d", bus.viol_id, bus.viol_cause);
    endtask

    task automatic test_invalid_region_and_reset();
        do_reset();
        bus.pc = 16'hC000; bus.dma_en = 1; bus.dma_addr = 16'hF000; tick();
        bus.dma_en = 1; bus.dma_addr = 16'hEF80; tick();
        n_checks++; if (bus.exec_reset !== 1'b0) begin n_fail++; $display("FAIL inverted_exec_reset: got %b want 0", bus.exec_reset); end
        bus.pc = 16'hE000; tick();
        bus.pc = 16'hE002; tick();
        n_checks++; if (bus.in_ucc !== 3'b001) begin n_fail++; $display("FAIL midreset_pre_in_ucc: got %b want 001", bus.in_ucc); end
        puc_rst = 1; #2;
        n_checks++; if (bus.in_ucc !== 3'b000) begin n_fail++; $display("FAIL midreset_in_ucc: got %b want 000", bus.in_ucc); end
        n_checks++; if (bus.exec_reset !== 1'b0) begin n_fail++; $display("FAIL midreset_exec_reset: got %b want 0", bus.exec_reset); end
        n_checks++; if ({bus.viol_id, bus.viol_cause} !== 6'd0) begin n_fail++; $display("FAIL midreset_viol: got %0d/%0d want 0/0", bus.viol_id, bus.viol_cause); end
        puc_rst = 0; model_reset();
        bus.pc = 16'hE000; tick();
        n_checks++; if (bus.in_ucc !== 3'b001) begin n_fail++; $display("FAIL reentry_in_ucc: got %b want 001", bus.in_ucc); end
        bus.pc = 16'hE0FE; tick();
        bus.pc = 16'hC000; tick();
        n_checks++; if (bus.in_ucc !== 3'b000) begin n_fail++; $display("FAIL reentry_exit_in_ucc: got %b want 000", bus.in_ucc); end
        n_checks++; if (bus.exec_reset !== 1'b0) begin n_fail++; $display("FAIL reentry_exec_reset: got %b want 0", bus.exec_reset); end
        $display("mid-region reset and clean re-entry in_ucc=%b exec_reset=%b", bus.in_ucc, bus.exec_reset);
    endtask

    task automatic test_random();
        int r;
        int reg_sel;
        logic [15:0] lo, hi;
        for (int t = 0; t < 800; t++) begin
            if (t % 24 == 0) begin
                for (int i = 0; i < NUM; i++) begin
                    lo = 16'($urandom_range(0, 48));
                    hi = lo + 16'($urandom_range(0, 12));
                    if ($urandom_range(0, 5) == 0) begin
                        bus.ucc_min[i] = hi + 16'd1; bus.ucc_max[i] = lo;
                    end else begin
                        bus.ucc_min[i] = lo; bus.ucc_max[i] = hi;
                    end
                end
                do_reset();
            end else if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end
            reg_sel = $urandom_range(0, NUM - 1);
            r = $urandom_range(0, 9);
            if (r < 3)      bus.pc = bus.ucc_min[reg_sel];
            else if (r < 5) bus.pc = bus.ucc_max[reg_sel];
            else if (r < 7) bus.pc = bus.pc + 16'd1;
            else            bus.pc = 16'($urandom_range(0, 63));
            bus.irq       = ($urandom_range(0, 15) == 0);
            bus.data_wr   = ($urandom_range(0, 11) == 0);
            bus.data_addr = 16'($urandom_range(0, 63));
            bus.dma_en    = ($urandom_range(0, 11) == 0);
            bus.dma_addr  = 16'($urandom_range(0, 63));
            tick();
            n_checks++; if (bus.in_ucc !== m_in_vec()) begin n_fail++; $display("FAIL rand_in_ucc t=%0d: got %b want %b", t, bus.in_ucc, m_in_vec()); end
            n_checks++; if (bus.exec_reset !== m_exec) begin n_fail++; $display("FAIL rand_exec_reset t=%0d: got %b want %b", t, bus.exec_reset, m_exec); end
            n_checks++; if (bus.viol_id !== m_id) begin n_fail++; $display("FAIL rand_viol_id t=%0d: got %0d want %0d", t, bus.viol_id, m_id); end
            n_checks++; if (bus.viol_cause !== m_cause) begin n_fail++; $display("FAIL rand_viol_cause t=%0d: got %0d want %0d", t, bus.viol_cause, m_cause); end
            $display("rand t=%0d pc=%h in_ucc=%b exec_reset=%b id=%0d cause=%0d", t, bus.pc, bus.in_ucc, bus.exec_reset, bus.viol_id, bus.viol_cause);
        end
        set_default_regions();
    endtask

    initial begin
        bus.pc = 16'h0; bus.irq = 0; bus.data_wr = 0; bus.data_addr = 16'h0;
        bus.dma_en = 0; bus.dma_addr = 16'h0;
        set_default_regions();
        model_reset();
        test_reset();
        test_legal_pass();
        test_min_eq_max();
        test_illegal_entry();
        test_irq();
        test_write_overlap();
        test_invalid_region_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
